// File: rtl/mac_unit.sv
// mac_unit: fixed-point multiply-accumulate neuron with pipelined
// operand fetch, saturating rescale and selectable activation.
module mac_unit #(
  parameter int D_LEN  = 16,
  parameter int FRAC   = 8,
  parameter int AWIDTH = 8,
  parameter int LL     = 8,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AWIDTH:0]         mac_ctrl,
  input  logic [3:0]              acftype,
  input  logic signed [D_LEN-1:0] a_din,
  input  logic signed [D_LEN-1:0] w_din,
  output logic [LL-1:0]           mac_addr,
  output logic signed [D_LEN-1:0] mac_dout,
  output logic                    mac_finish,
  output logic                    mac_busy
);

  localparam int ACC_W = 2 * D_LEN + LL;

  localparam logic signed [ACC_W-1:0] C_MAX =
    ACC_W'({1'b0, {(D_LEN-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;
  localparam logic signed [D_LEN-1:0] D_MAX =
    {1'b0, {(D_LEN-1){1'b1}}};
  localparam logic signed [D_LEN-1:0] D_MIN = ~D_MAX;
  localparam logic signed [D_LEN-1:0] C_ONE =
    D_LEN'(1) << FRAC;
  localparam logic signed [D_LEN-1:0] C_MONE = -C_ONE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_ACT,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_start_d;
  logic [AWIDTH-1:0]        r_loop;
  logic [3:0]               r_acf;
  logic signed [ACC_W-1:0]  r_acc;
  logic [RD_LAT:0]          r_vld;
  logic [RD_LAT:0]          r_last;

  logic                     w_rise;
  logic                     w_accept;
  logic                     w_issue;
  logic                     w_issue_last;
  logic                     w_done_acc;
  logic [LL-1:0]            w_loop_ext;
  logic [LL-1:0]            w_addr_nxt;
  logic signed [2*D_LEN-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [D_LEN-1:0]  w_sat;
  logic signed [D_LEN-1:0]  w_act;

  assign w_rise     = mac_ctrl[0] & ~r_start_d;
  assign w_accept   = w_rise &
                      ((r_state == S_IDLE) |
                       (r_state == S_DONE));
  assign w_loop_ext = LL'(r_loop);
  assign w_addr_nxt = mac_addr + LL'(1);
  assign w_done_acc = r_vld[RD_LAT] & r_last[RD_LAT];

  // Each issued address carries a valid/last tag down the read pipe.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    if (w_accept) begin
      w_issue      = 1'b1;
      w_issue_last = (mac_ctrl[AWIDTH:1] == '0);
    end else if (r_state == S_FETCH &&
                 mac_addr != w_loop_ext) begin
      w_issue      = 1'b1;
      w_issue_last = (w_addr_nxt == w_loop_ext);
    end
  end

  assign w_prod     = a_din * w_din;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_shift    = r_acc >>> FRAC;

  always_comb begin
    w_sat = w_shift[D_LEN-1:0];
    if (w_shift > C_MAX) begin
      w_sat = D_MAX;
    end else if (w_shift < C_MIN) begin
      w_sat = D_MIN;
    end
    w_act = w_sat;
    case (r_acf)
      4'd1: begin
        if (w_sat[D_LEN-1]) w_act = '0;
      end
      4'd2: begin
        if (w_sat[D_LEN-1]) w_act = '0;
        else if (w_sat > C_ONE) w_act = C_ONE;
      end
      4'd3: begin
        if (w_sat > C_ONE) w_act = C_ONE;
        else if (w_sat < C_MONE) w_act = C_MONE;
      end
      default: w_act = w_sat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b1;
      r_loop     <= '0;
      r_acf      <= '0;
      r_acc      <= '0;
      r_vld      <= '0;
      r_last     <= '0;
      mac_addr   <= '0;
      mac_dout   <= '0;
      mac_finish <= 1'b0;
      mac_busy   <= 1'b0;
    end else begin
      r_start_d <= mac_ctrl[0];
      r_vld[0]  <= w_issue;
      r_last[0] <= w_issue_last;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_last[i] <= r_last[i-1];
      end
      if (r_vld[RD_LAT]) r_acc <= r_acc + w_prod_ext;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_loop     <= mac_ctrl[AWIDTH:1];
            r_acf      <= acftype;
            r_acc      <= '0;
            mac_addr   <= '0;
            mac_finish <= 1'b0;
            mac_busy   <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mac_addr != w_loop_ext) begin
            mac_addr <= w_addr_nxt;
          end else if (w_done_acc) begin
            r_state <= S_ACT;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_done_acc) r_state <= S_ACT;
        end
        S_ACT: begin
          mac_dout   <= w_act;
          mac_finish <= 1'b1;
          mac_busy   <= 1'b0;
          r_state    <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: vector table, corner sequences and random runs
// against an arithmetic reference of the neuron computation.
module tb_mac_unit;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  mac_ctrl = '0;
  logic [3:0]  acftype = '0;
  logic [15:0] a_din;
  logic [15:0] w_din;
  logic [7:0]  mac_addr;
  logic [15:0] mac_dout;
  logic        mac_finish;
  logic        mac_busy;

  logic [15:0] a_mem [256];
  logic [15:0] w_mem [256];
  logic [7:0]  ad1 = '0;
  logic [7:0]  ad2 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string            nm;
    int               lp;
    int               acf;
    logic [3:0][15:0] a;
    logic [3:0][15:0] w;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl[$];

  mac_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mac_ctrl   (mac_ctrl),
    .acftype    (acftype),
    .a_din      (a_din),
    .w_din      (w_din),
    .mac_addr   (mac_addr),
    .mac_dout   (mac_dout),
    .mac_finish (mac_finish),
    .mac_busy   (mac_busy)
  );

  always #5 clk = ~clk;

  // Memory with a two-cycle read latency.
  always @(posedge clk) begin
    ad1 <= mac_addr;
    ad2 <= ad1;
  end
  assign a_din = a_mem[ad2];
  assign w_din = w_mem[ad2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 511)) - 16'd256;
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < 256; k++) begin
      a_mem[k] = rnd16();
      w_mem[k] = rnd16();
    end
  endtask

  // Dot product in plain integers, then rescale, clamp, activate.
  function automatic logic [15:0] model(input int lp,
                                        input int acf);
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k <= lp; k++)
      s += longint'($signed(a_mem[k])) *
           longint'($signed(w_mem[k]));
    r = s >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    case (acf)
      1: if (r < 0) r = 0;
      2: begin
        if (r < 0) r = 0;
        if (r > 256) r = 256;
      end
      3: begin
        if (r > 256) r = 256;
        if (r < -256) r = -256;
      end
      default: r = r;
    endcase
    return 16'(r);
  endfunction

  task automatic add(input string nm, input int lp,
                     input int acf,
                     input logic [15:0] a0, a1, a2, a3,
                     input logic [15:0] w0, w1, w2, w3,
                     input logic [15:0] exp);
    vec_t v;
    v.nm = nm;
    v.lp = lp;
    v.acf = acf;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_op(input string nm, input int lp,
                        input int acf,
                        input logic [15:0] exp,
                        input int hold, input int rr);
    int n;
    @(negedge clk);
    mac_ctrl = {lp[7:0], 1'b1};
    acftype  = acf[3:0];
    @(negedge clk);
    chk({nm, ".e0_fin"}, 32'(mac_finish), 0);
    chk({nm, ".e0_busy"}, 32'(mac_busy), 1);
    n = 0;
    while (!mac_finish && n < 600) begin
      chk({nm, ".addr"}, 32'(mac_addr),
          (n <= lp) ? n : lp);
      mac_ctrl[0] = (n + 1 < hold) || (n == rr);
      @(negedge clk);
      n++;
    end
    mac_ctrl[0] = 1'b0;
    chk({nm, ".fin_edge"}, n, lp + RD_LAT + 2);
    chk({nm, ".dout"}, 32'(mac_dout), 32'(exp));
    chk({nm, ".busy_off"}, 32'(mac_busy), 0);
    repeat (2) @(negedge clk);
    chk({nm, ".hold_fin"}, 32'(mac_finish), 1);
    chk({nm, ".hold_dout"}, 32'(mac_dout), 32'(exp));
  endtask

  initial begin
    logic saw;
    fill_rand();

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.addr", 32'(mac_addr), 0);
    chk("rst.dout", 32'(mac_dout), 0);
    chk("rst.fin", 32'(mac_finish), 0);
    chk("rst.busy", 32'(mac_busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(mac_busy), 0);

    add("v032", 2, 0, 16'h0100, 16'h0200, 16'h0080, 0,
        16'h0080, 16'h0040, 16'h0100, 0, 16'h0180);
    add("relu_neg", 0, 1, 16'h0100, 0, 0, 0,
        16'hFF00, 0, 0, 0, 16'h0000);
    add("tanh_m1", 0, 3, 16'h0100, 0, 0, 0,
        16'hFF00, 0, 0, 0, 16'hFF00);
    add("sat_pos", 3, 0, 16'h7F00, 16'h7F00, 16'h7F00,
        16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
        16'h7F00, 16'h7FFF);
    add("sat_neg", 3, 0, 16'h7F00, 16'h7F00, 16'h7F00,
        16'h7F00, 16'h8100, 16'h8100, 16'h8100,
        16'h8100, 16'h8000);
    add("hsig_hi", 0, 2, 16'h0180, 0, 0, 0,
        16'h0100, 0, 0, 0, 16'h0100);
    add("hsig_lo", 0, 2, 16'hFF80, 0, 0, 0,
        16'h0100, 0, 0, 0, 16'h0000);
    add("tanh_lo", 0, 3, 16'hFE80, 0, 0, 0,
        16'h0100, 0, 0, 0, 16'hFF00);
    add("lin_acf7", 0, 7, 16'h0180, 0, 0, 0,
        16'h0100, 0, 0, 0, 16'h0180);
    add("trunc", 0, 0, 16'h0001, 0, 0, 0,
        16'hFFFF, 0, 0, 0, 16'hFFFF);
    add("relu_pos", 1, 1, 16'h0300, 16'h0100, 0, 0,
        16'h0100, 16'hFE00, 0, 0, 16'h0100);

    foreach (tbl[i]) begin
      fill_rand();
      for (int k = 0; k <= tbl[i].lp; k++) begin
        a_mem[k] = tbl[i].a[k];
        w_mem[k] = tbl[i].w[k];
      end
      run_op(tbl[i].nm, tbl[i].lp, tbl[i].acf,
             tbl[i].exp, 1, -1);
    end

    // Reset during FETCH with start held across release.
    fill_rand();
    @(negedge clk);
    mac_ctrl = {8'd10, 1'b1};
    acftype  = 4'd0;
    repeat (3) @(negedge clk);
    chk("mid.busy", 32'(mac_busy), 1);
    chk("mid.addr", 32'(mac_addr), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid.rst_addr", 32'(mac_addr), 0);
    chk("mid.rst_dout", 32'(mac_dout), 0);
    chk("mid.rst_fin", 32'(mac_finish), 0);
    chk("mid.rst_busy", 32'(mac_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (mac_finish || mac_busy ||
          mac_addr != 0 || mac_dout != 0)
        saw = 1'b1;
    end
    chk("mid.no_run", 32'(saw), 0);
    mac_ctrl[0] = 1'b0;
    run_op("post_rst", 10, 0, model(10, 0), 1, -1);

    // Long start level and a re-rise during FETCH.
    fill_rand();
    a_mem[0] = 16'h0100; w_mem[0] = 16'h0080;
    a_mem[1] = 16'h0200; w_mem[1] = 16'h0040;
    a_mem[2] = 16'h0080; w_mem[2] = 16'h0100;
    run_op("hold3", 2, 0, 16'h0180, 3, -1);
    fill_rand();
    run_op("rerise", 5, 0, model(5, 0), 1, 1);

    for (int it = 0; it < 25; it++) begin
      int lp;
      int acf;
      int hold;
      int rr;
      lp   = $urandom_range(0, 20);
      acf  = $urandom_range(0, 15);
      hold = $urandom_range(1, 3);
      rr   = -1;
      if (hold + 1 <= lp && $urandom_range(0, 1) == 1)
        rr = hold;
      fill_rand();
      run_op("rnd", lp, acf, model(lp, acf), hold, rr);
    end

    fill_rand();
    run_op("max_loop", 255, 3, model(255, 3), 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 Parameter D_LEN, 16, signed two's-complement data width of states, weights and result.
REQ-002 Parameter FRAC, 8, fractional bits of the fixed-point format (Q(D_LEN-FRAC).FRAC).
REQ-003 Parameter AWIDTH, 8, width of the loop field in mac_ctrl.
REQ-004 Parameter LL, 8, width of mac_addr; AWIDTH <= LL SHALL hold.
REQ-005 Parameter RD_LAT, 2, cycles from mac_addr change to the matching data on a_din/w_din.
REQ-006 clk  in  1  single clock; all logic on posedge clk.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 mac_ctrl  in  AWIDTH+1  bit0 = start (level, may stay high several cycles); [AWIDTH:1] = loop = connection length minus 1.
REQ-009 acftype  in  4  activation function select, sampled at start.
REQ-010 a_din  in  D_LEN  state value read for the current element.
REQ-011 w_din  in  D_LEN  weight read for the current element.
REQ-012 mac_addr  out  LL  element index; the router adds its own base addresses.
REQ-013 mac_dout  out  D_LEN  activated neuron result.
REQ-014 mac_finish  out  1  high while the result is valid.
REQ-015 mac_busy  out  1  high from the accepted start until mac_finish rises.

Function
REQ-016 States: IDLE, FETCH, DRAIN, ACT, DONE.
REQ-017 A start is accepted only on a 0->1 transition of mac_ctrl[0], and only in IDLE or DONE. A transition in any other state SHALL be ignored.
REQ-018 Acceptance edge E0: latch loop and acftype, clear the accumulator, mac_addr<=0, mac_finish<=0, mac_busy<=1, state->FETCH.
REQ-019 FETCH: mac_addr SHALL increment by 1 per cycle, so mac_addr=k after edge Ek, for k=0..loop. After mac_addr reaches loop, it SHALL hold at loop and the state SHALL go to DRAIN.
REQ-020 Element k SHALL be sampled from a_din/w_din at edge E(k+RD_LAT+1), tracked by a RD_LAT+1 deep valid pipeline.
REQ-021 Each sample: acc <= acc + a_din*w_din, using signed full-precision products; the accumulator is 2*D_LEN+LL bits signed and never wraps.
REQ-022 DRAIN lasts until the last element is accumulated at E(loop+RD_LAT+1); the state then goes to ACT.
REQ-023 ACT: r = acc arithmetic-shifted right by FRAC (truncation), then saturated to [-2^(D_LEN-1), 2^(D_LEN-1)-1].
REQ-024 Activation is applied to r:
- acftype 0 = linear.
- acftype 1 = ReLU, negative values become 0.
- acftype 2 = hard sigmoid, clip to [0, 1.0].
- acftype 3 = hard tanh, clip to [-1.0, 1.0].
- acftype 4..15 = linear.
REQ-025 At edge E(loop+RD_LAT+2), mac_dout SHALL be registered, mac_finish SHALL go to 1, mac_busy SHALL go to 0, and the state SHALL go to DONE.
REQ-026 In DONE, mac_dout and mac_finish SHALL hold until the next accepted start, which clears mac_finish at its E0.
REQ-027 loop=0 is legal and gives one product; finish at E(RD_LAT+2).
REQ-028 a_din/w_din SHALL be ignored outside the valid pipeline slots.

Reset
REQ-029 With rst_n=0 at a posedge, on that edge: state=IDLE, mac_addr=0, mac_dout=0, mac_finish=0, mac_busy=0, accumulator=0, valid pipeline cleared.
REQ-030 The start-history register SHALL reset to 1, so a start held high through reset release is not accepted.
REQ-031 Reset mid-operation SHALL abort the operation with no result and no finish pulse.

Verification
REQ-032 loop=2, acf=0, a={0x0100,0x0200,0x0080}, w={0x0080,0x0040,0x0100} -> mac_addr 0,1,2; mac_finish rises at E6; mac_dout=0x0180.
REQ-033 loop=0, acf=1, a=0x0100, w=0xFF00 -> mac_dout=0x0000 at E4; same inputs with acf=3 -> 0xFF00.
REQ-034 loop=3, acf=0, all a=w=0x7F00 -> mac_dout=0x7FFF (saturated); with all w=0x8100 -> 0x8000.
REQ-035 Result 1.5 with acf=2 -> 0x0100; result -0.5 with acf=2 -> 0x0000.
REQ-036 Start held high for 3 cycles -> exactly one run. A second start rise during FETCH is ignored. A start rise in DONE -> mac_finish drops at E0 and a new result follows.
REQ-037 rst_n low during FETCH with start high across release -> all outputs 0 and no run, until start falls and rises again.
